// File: rtl/ex_unit_pkg.sv
//==============================================================================
// Package : ex_unit_pkg
// Desc    : Shared ROB tag width and opcode encoding for the execute stage.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package ex_unit_pkg;

    localparam int ROBBW = 4;

    localparam logic [5:0] c_op_lui   = 6'd1;
    localparam logic [5:0] c_op_auipc = 6'd2;
    localparam logic [5:0] c_op_jal   = 6'd3;
    localparam logic [5:0] c_op_jalr  = 6'd4;
    localparam logic [5:0] c_op_beq   = 6'd5;
    localparam logic [5:0] c_op_bne   = 6'd6;
    localparam logic [5:0] c_op_blt   = 6'd7;
    localparam logic [5:0] c_op_bge   = 6'd8;
    localparam logic [5:0] c_op_bltu  = 6'd9;
    localparam logic [5:0] c_op_bgeu  = 6'd10;
    // Codes 11..18 are loads/stores, handled by the LSB rather than here.
    localparam logic [5:0] c_op_addi  = 6'd19;
    localparam logic [5:0] c_op_slti  = 6'd20;
    localparam logic [5:0] c_op_sltiu = 6'd21;
    localparam logic [5:0] c_op_xori  = 6'd22;
    localparam logic [5:0] c_op_ori   = 6'd23;
    localparam logic [5:0] c_op_andi  = 6'd24;
    localparam logic [5:0] c_op_slli  = 6'd25;
    localparam logic [5:0] c_op_srli  = 6'd26;
    localparam logic [5:0] c_op_srai  = 6'd27;
    localparam logic [5:0] c_op_add   = 6'd28;
    localparam logic [5:0] c_op_sub   = 6'd29;
    localparam logic [5:0] c_op_sll   = 6'd30;
    localparam logic [5:0] c_op_slt   = 6'd31;
    localparam logic [5:0] c_op_sltu  = 6'd32;
    localparam logic [5:0] c_op_xor   = 6'd33;
    localparam logic [5:0] c_op_srl   = 6'd34;
    localparam logic [5:0] c_op_sra   = 6'd35;
    localparam logic [5:0] c_op_or    = 6'd36;
    localparam logic [5:0] c_op_and   = 6'd37;

endpackage

`default_nettype wire

// File: rtl/ex_unit_alu.sv
//==============================================================================
// Module : alu_core
// Desc   : Combinational RV32I ALU / branch / jump resolution.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module alu_core
    import ex_unit_pkg::*;
(
    input  logic [5:0]  i_code,
    input  logic [31:0] i_v1,
    input  logic [31:0] i_v2,
    input  logic [31:0] i_a,
    input  logic [31:0] i_pc,
    output logic [31:0] o_val,
    output logic        o_jump,
    output logic [31:0] o_target
);

    logic [31:0] w_pc4;
    logic [31:0] w_pc_a;
    logic [31:0] w_jalr;
    logic        w_is_br;
    logic        w_taken;

    assign w_pc4  = i_pc + 32'd4;
    assign w_pc_a = i_pc + i_a;
    assign w_jalr = i_v1 + i_a;

    always_comb begin
        o_val    = 32'd0;
        o_jump   = 1'b0;
        o_target = w_pc4;
        w_is_br  = 1'b0;
        w_taken  = 1'b0;
        case (i_code)
            c_op_lui:   o_val = i_a;
            c_op_auipc: o_val = w_pc_a;
            c_op_jal: begin
                o_val    = w_pc4;
                o_target = w_pc_a;
                o_jump   = 1'b1;
            end
            c_op_jalr: begin
                o_val    = w_pc4;
                o_target = w_jalr & ~32'd1;
                o_jump   = 1'b1;
            end
            c_op_beq:   begin w_is_br = 1'b1; w_taken = (i_v1 == i_v2); end
            c_op_bne:   begin w_is_br = 1'b1; w_taken = (i_v1 != i_v2); end
            c_op_blt:   begin w_is_br = 1'b1; w_taken = ($signed(i_v1) <  $signed(i_v2)); end
            c_op_bge:   begin w_is_br = 1'b1; w_taken = ($signed(i_v1) >= $signed(i_v2)); end
            c_op_bltu:  begin w_is_br = 1'b1; w_taken = (i_v1 <  i_v2); end
            c_op_bgeu:  begin w_is_br = 1'b1; w_taken = (i_v1 >= i_v2); end
            c_op_addi:  o_val = i_v1 + i_a;
            c_op_slti:  o_val = {31'd0, ($signed(i_v1) < $signed(i_a))};
            c_op_sltiu: o_val = {31'd0, (i_v1 < i_a)};
            c_op_xori:  o_val = i_v1 ^ i_a;
            c_op_ori:   o_val = i_v1 | i_a;
            c_op_andi:  o_val = i_v1 & i_a;
            c_op_slli:  o_val = i_v1 << i_a[4:0];
            c_op_srli:  o_val = i_v1 >> i_a[4:0];
            c_op_srai:  o_val = $signed(i_v1) >>> i_a[4:0];
            c_op_add:   o_val = i_v1 + i_v2;
            c_op_sub:   o_val = i_v1 - i_v2;
            c_op_sll:   o_val = i_v1 << i_v2[4:0];
            c_op_slt:   o_val = {31'd0, ($signed(i_v1) < $signed(i_v2))};
            c_op_sltu:  o_val = {31'd0, (i_v1 < i_v2)};
            c_op_xor:   o_val = i_v1 ^ i_v2;
            c_op_srl:   o_val = i_v1 >> i_v2[4:0];
            c_op_sra:   o_val = $signed(i_v1) >>> i_v2[4:0];
            c_op_or:    o_val = i_v1 | i_v2;
            c_op_and:   o_val = i_v1 & i_v2;
            default:    o_val = 32'd0;
        endcase
        // Branches leave val at 0 and only redirect when taken.
        if (w_is_br) begin
            o_jump   = w_taken;
            o_target = w_taken ? w_pc_a : w_pc4;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_unit.sv
//==============================================================================
// Module : ex_unit
// Desc   : Registered RV32I execute stage broadcasting on the execute CDB.
// Config : EX_PIPE2_EN adds an operand register stage (latency 2).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ex_unit
    import ex_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_wrong,
    input  logic             exe_RS_flag,
    input  logic [31:0]      exe_RS_V1,
    input  logic [31:0]      exe_RS_V2,
    input  logic [31:0]      exe_RS_A,
    input  logic [31:0]      exe_RS_pc,
    input  logic [5:0]       exe_RS_code,
    input  logic [ROBBW-1:0] exe_RS_rob_id,
    output logic             ex_cdb_flag,
    output logic [ROBBW-1:0] ex_cdb_rob_id,
    output logic [31:0]      ex_cdb_val,
    output logic             ex_cdb_jump,
    output logic [31:0]      ex_cdb_target
);

    logic             w_vld;
    logic [5:0]       w_code;
    logic [31:0]      w_v1;
    logic [31:0]      w_v2;
    logic [31:0]      w_a;
    logic [31:0]      w_pc;
    logic [ROBBW-1:0] w_rob;

    logic [31:0]      w_alu_val;
    logic             w_alu_jump;
    logic [31:0]      w_alu_target;

`ifdef EX_PIPE2_EN
    logic             r_s1_vld;
    logic [5:0]       r_s1_code;
    logic [31:0]      r_s1_v1;
    logic [31:0]      r_s1_v2;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_pc;
    logic [ROBBW-1:0] r_s1_rob;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_code <= 6'd0;
            r_s1_v1   <= 32'd0;
            r_s1_v2   <= 32'd0;
            r_s1_a    <= 32'd0;
            r_s1_pc   <= 32'd0;
            r_s1_rob  <= '0;
        end else if (jump_wrong) begin
            r_s1_vld <= 1'b0;
        end else if (rdy) begin
            r_s1_vld <= exe_RS_flag;
            if (exe_RS_flag) begin
                r_s1_code <= exe_RS_code;
                r_s1_v1   <= exe_RS_V1;
                r_s1_v2   <= exe_RS_V2;
                r_s1_a    <= exe_RS_A;
                r_s1_pc   <= exe_RS_pc;
                r_s1_rob  <= exe_RS_rob_id;
            end
        end
    end

    assign w_vld  = r_s1_vld;
    assign w_code = r_s1_code;
    assign w_v1   = r_s1_v1;
    assign w_v2   = r_s1_v2;
    assign w_a    = r_s1_a;
    assign w_pc   = r_s1_pc;
    assign w_rob  = r_s1_rob;
`else
    assign w_vld  = exe_RS_flag;
    assign w_code = exe_RS_code;
    assign w_v1   = exe_RS_V1;
    assign w_v2   = exe_RS_V2;
    assign w_a    = exe_RS_A;
    assign w_pc   = exe_RS_pc;
    assign w_rob  = exe_RS_rob_id;
`endif

    alu_core u_alu (
        .i_code   (w_code),
        .i_v1     (w_v1),
        .i_v2     (w_v2),
        .i_a      (w_a),
        .i_pc     (w_pc),
        .o_val    (w_alu_val),
        .o_jump   (w_alu_jump),
        .o_target (w_alu_target)
    );

    logic             r_flag;
    logic [ROBBW-1:0] r_rob;
    logic [31:0]      r_val;
    logic             r_jump;
    logic [31:0]      r_target;

    // Data registers only load on a real result so they hold across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag   <= 1'b0;
            r_rob    <= '0;
            r_val    <= 32'd0;
            r_jump   <= 1'b0;
            r_target <= 32'd0;
        end else if (jump_wrong) begin
            r_flag <= 1'b0;
        end else if (rdy) begin
            r_flag <= w_vld;
            if (w_vld) begin
                r_rob    <= w_rob;
                r_val    <= w_alu_val;
                r_jump   <= w_alu_jump;
                r_target <= w_alu_target;
            end
        end
    end

    assign ex_cdb_flag   = r_flag;
    assign ex_cdb_rob_id = r_rob;
    assign ex_cdb_val    = r_val;
    assign ex_cdb_jump   = r_jump;
    assign ex_cdb_target = r_target;

endmodule

`default_nettype wire

// File: tb/tb_ex_unit.sv
//==============================================================================
// Module : tb_ex_unit
// Desc   : Directed self-checking bench for ex_unit (either EX_PIPE2_EN build).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_ex_unit;
    import ex_unit_pkg::*;

    logic             clk;
    logic             clk_en;
    logic             rst;
    logic             rdy;
    logic             jump_wrong;
    logic             exe_RS_flag;
    logic [31:0]      exe_RS_V1;
    logic [31:0]      exe_RS_V2;
    logic [31:0]      exe_RS_A;
    logic [31:0]      exe_RS_pc;
    logic [5:0]       exe_RS_code;
    logic [ROBBW-1:0] exe_RS_rob_id;
    logic             ex_cdb_flag;
    logic [ROBBW-1:0] ex_cdb_rob_id;
    logic [31:0]      ex_cdb_val;
    logic             ex_cdb_jump;
    logic [31:0]      ex_cdb_target;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic [5:0]  code;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] a;
        logic [31:0] pc;
        logic [31:0] val;
        logic        jump;
        logic [31:0] tgt;
    } vec_t;

    ex_unit dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .jump_wrong    (jump_wrong),
        .exe_RS_flag   (exe_RS_flag),
        .exe_RS_V1     (exe_RS_V1),
        .exe_RS_V2     (exe_RS_V2),
        .exe_RS_A      (exe_RS_A),
        .exe_RS_pc     (exe_RS_pc),
        .exe_RS_code   (exe_RS_code),
        .exe_RS_rob_id (exe_RS_rob_id),
        .ex_cdb_flag   (ex_cdb_flag),
        .ex_cdb_rob_id (ex_cdb_rob_id),
        .ex_cdb_val    (ex_cdb_val),
        .ex_cdb_jump   (ex_cdb_jump),
        .ex_cdb_target (ex_cdb_target)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    // Present one issue, step past the capturing edge, then step through any extra pipe stage.
    task automatic do_op(input logic [5:0] code, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] a, input logic [31:0] pc, input logic [ROBBW-1:0] rob);
        exe_RS_flag   = 1'b1;
        exe_RS_code   = code;
        exe_RS_V1     = v1;
        exe_RS_V2     = v2;
        exe_RS_A      = a;
        exe_RS_pc     = pc;
        exe_RS_rob_id = rob;
        @(posedge clk); #1;
        exe_RS_flag = 1'b0;
`ifdef EX_PIPE2_EN
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_tests++;
        if ({ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_target} !== '0) begin
            n_fail++;
            $display("FAIL reset_no_clk: flag=%0b rob=%0d val=%h jump=%0b tgt=%h, required all 0",
                     ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_target);
        end
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_target} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: flag=%0b rob=%0d val=%h jump=%0b tgt=%h, required all 0",
                     ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_target);
        end
    endtask

    task automatic test_alu();
        vec_t tbl [22];
        logic [ROBBW-1:0] rob;
        tbl[0]  = '{c_op_add,   32'hFFFFFFFF, 32'd1,        32'd0,        32'h200,  32'h0,        1'b0, 32'h204};
        tbl[1]  = '{c_op_sra,   32'h80000000, 32'd4,        32'd0,        32'h204,  32'hF8000000, 1'b0, 32'h208};
        tbl[2]  = '{c_op_srai,  32'h80000000, 32'd0,        32'h404,      32'h208,  32'hF8000000, 1'b0, 32'h20C};
        tbl[3]  = '{c_op_sltu,  32'd1,        32'hFFFFFFFF, 32'd0,        32'h20C,  32'd1,        1'b0, 32'h210};
        tbl[4]  = '{c_op_blt,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b1, 32'h120};
        tbl[5]  = '{c_op_bgeu,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b1, 32'h120};
        tbl[6]  = '{c_op_bge,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b0, 32'h104};
        tbl[7]  = '{c_op_bltu,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  32'd0,        1'b0, 32'h104};
        tbl[8]  = '{c_op_jalr,  32'h1003,     32'd0,        32'd2,        32'h40,   32'h44,       1'b1, 32'h1004};
        tbl[9]  = '{c_op_lui,   32'd0,        32'd0,        32'h12345000, 32'h500,  32'h12345000, 1'b0, 32'h504};
        tbl[10] = '{c_op_auipc, 32'd0,        32'd0,        32'h2000,     32'h1000, 32'h3000,     1'b0, 32'h1004};
        tbl[11] = '{c_op_jal,   32'd0,        32'd0,        32'hFFFFFFF0, 32'h80,   32'h84,       1'b1, 32'h70};
        tbl[12] = '{c_op_sub,   32'd5,        32'd7,        32'd0,        32'd0,    32'hFFFFFFFE, 1'b0, 32'h4};
        tbl[13] = '{c_op_slt,   32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,    32'd1,        1'b0, 32'h4};
        tbl[14] = '{c_op_xori,  32'hF0F0,     32'd0,        32'h0FF0,     32'd0,    32'hFF00,     1'b0, 32'h4};
        tbl[15] = '{c_op_slli,  32'd1,        32'd0,        32'h21,       32'd0,    32'd2,        1'b0, 32'h4};
        tbl[16] = '{c_op_srl,   32'h80000000, 32'h24,       32'd0,        32'd0,    32'h08000000, 1'b0, 32'h4};
        tbl[17] = '{6'd63,      32'd5,        32'd6,        32'd0,        32'h300,  32'd0,        1'b0, 32'h304};
        tbl[18] = '{c_op_beq,   32'd7,        32'd7,        32'd8,        32'd0,    32'd0,        1'b1, 32'h8};
        tbl[19] = '{c_op_bne,   32'd7,        32'd7,        32'd8,        32'd0,    32'd0,        1'b0, 32'h4};
        tbl[20] = '{c_op_sltiu, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0,    32'd1,        1'b0, 32'h4};
        tbl[21] = '{c_op_and,   32'hF0F0,     32'h0FF0,     32'd0,        32'd0,    32'h00F0,     1'b0, 32'h4};
        for (int i = 0; i < 22; i++) begin
            rob = ROBBW'((i % 15) + 1);
            do_op(tbl[i].code, tbl[i].v1, tbl[i].v2, tbl[i].a, tbl[i].pc, rob);
            n_tests++;
            if (ex_cdb_flag !== 1'b1 || ex_cdb_rob_id !== rob) begin
                n_fail++;
                $display("FAIL alu_%0d_tag: flag=%0b rob=%0d, required flag=1 rob=%0d",
                         i, ex_cdb_flag, ex_cdb_rob_id, rob);
            end
            n_tests++;
            if (ex_cdb_val !== tbl[i].val) begin
                n_fail++;
                $display("FAIL alu_%0d_val: got %h, required %h", i, ex_cdb_val, tbl[i].val);
            end
            n_tests++;
            if (ex_cdb_jump !== tbl[i].jump || ex_cdb_target !== tbl[i].tgt) begin
                n_fail++;
                $display("FAIL alu_%0d_ctrl: jump=%0b tgt=%h, required jump=%0b tgt=%h",
                         i, ex_cdb_jump, ex_cdb_target, tbl[i].jump, tbl[i].tgt);
            end
        end
    endtask

    task automatic test_single_pulse();
        do_op(c_op_addi, 32'd100, 32'd0, 32'd23, 32'h600, 4'd9);
        n_tests++;
        if (ex_cdb_flag !== 1'b1 || ex_cdb_val !== 32'd123) begin
            n_fail++;
            $display("FAIL pulse_issue: flag=%0b val=%h, required flag=1 val=0000007b", ex_cdb_flag, ex_cdb_val);
        end
        @(posedge clk); #1;
        n_tests++;
        if (ex_cdb_flag !== 1'b0 || ex_cdb_rob_id !== 4'd9 || ex_cdb_val !== 32'd123 || ex_cdb_target !== 32'h604) begin
            n_fail++;
            $display("FAIL pulse_hold: flag=%0b rob=%0d val=%h tgt=%h, required flag=0 rob=9 val=0000007b tgt=00000604",
                     ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_target);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]       issue_pat;
        logic [7:0]       rdy_pat;
        logic [7:0]       jw_pat;
        logic [7:0]       exp_flag;
        logic [7:0]       chk_mask;
        logic [ROBBW-1:0] exp_rob [8];
        logic [31:0]      exp_val [8];
        issue_pat = 8'b0011_1111;
        rdy_pat   = 8'b1111_0011;
        jw_pat    = 8'b0010_0000;
`ifdef EX_PIPE2_EN
        exp_flag = 8'b0001_1110;
        chk_mask = 8'b1111_1110;
        exp_rob  = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2};
        exp_val  = '{32'd0, 32'd15, 32'd15, 32'd15, 32'd25, 32'd25, 32'd25, 32'd25};
`else
        exp_flag = 8'b0001_1111;
        chk_mask = 8'b1111_1111;
        exp_rob  = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
        exp_val  = '{32'd15, 32'd25, 32'd25, 32'd25, 32'd35, 32'd35, 32'd35, 32'd35};
`endif
        for (int c = 0; c < 8; c++) begin
            exe_RS_flag = issue_pat[c];
            exe_RS_code = c_op_addi;
            exe_RS_A    = 32'd5;
            exe_RS_pc   = 32'h700;
            exe_RS_V2   = 32'd0;
            case (c)
                0:       begin exe_RS_V1 = 32'd10; exe_RS_rob_id = 4'd1; end
                1:       begin exe_RS_V1 = 32'd20; exe_RS_rob_id = 4'd2; end
                5:       begin exe_RS_V1 = 32'd40; exe_RS_rob_id = 4'd4; end
                default: begin exe_RS_V1 = 32'd30; exe_RS_rob_id = 4'd3; end
            endcase
            rdy        = rdy_pat[c];
            jump_wrong = jw_pat[c];
            @(posedge clk); #1;
            n_tests++;
            if (ex_cdb_flag !== exp_flag[c]) begin
                n_fail++;
                $display("FAIL b2b_flag_c%0d: got %0b, required %0b", c, ex_cdb_flag, exp_flag[c]);
            end
            if (chk_mask[c]) begin
                n_tests++;
                if (ex_cdb_rob_id !== exp_rob[c] || ex_cdb_val !== exp_val[c]) begin
                    n_fail++;
                    $display("FAIL b2b_data_c%0d: rob=%0d val=%h, required rob=%0d val=%h",
                             c, ex_cdb_rob_id, ex_cdb_val, exp_rob[c], exp_val[c]);
                end
            end
        end
        rdy         = 1'b1;
        jump_wrong  = 1'b0;
        exe_RS_flag = 1'b0;
    endtask

    task automatic test_async_reset();
        do_op(c_op_addi, 32'd1, 32'd0, 32'd2, 32'h800, 4'd5);
        n_tests++;
        if (ex_cdb_flag !== 1'b1 || ex_cdb_val !== 32'd3) begin
            n_fail++;
            $display("FAIL areset_pre: flag=%0b val=%h, required flag=1 val=00000003", ex_cdb_flag, ex_cdb_val);
        end
        clk_en = 1'b0;
        #6 rst = 1'b1;
        #1;
        n_tests++;
        if ({ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_target} !== '0) begin
            n_fail++;
            $display("FAIL areset_clear: flag=%0b rob=%0d val=%h jump=%0b tgt=%h, required all 0",
                     ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val, ex_cdb_jump, ex_cdb_target);
        end
        #2 rst = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        clk_en        = 1'b0;
        rst           = 1'b0;
        rdy           = 1'b1;
        jump_wrong    = 1'b0;
        exe_RS_flag   = 1'b0;
        exe_RS_V1     = 32'd0;
        exe_RS_V2     = 32'd0;
        exe_RS_A      = 32'd0;
        exe_RS_pc     = 32'd0;
        exe_RS_code   = 6'd0;
        exe_RS_rob_id = '0;
        test_reset();
        test_alu();
        test_single_pulse();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
